// File: rtl/signal_pkg.sv
// rtl/signal_pkg.sv - shared types and edge-mode decode for the input conditioner
package signal_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  function automatic logic edge_select(input edge_mode_t mode, input logic rise, input logic fall);
    logic sel;
    sel = 1'b0;
    case (mode)
      EDGE_NONE: sel = 1'b0;
      EDGE_RISE: sel = rise;
      EDGE_FALL: sel = fall;
      EDGE_BOTH: sel = rise | fall;
      default:   sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/signal_conditioner_channel.sv
// rtl/signal_conditioner_channel.sv - one channel: sync chain, stability filter, edges, sticky pending
module signal_conditioner_channel
  import signal_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic       clk_i,
  input  logic       nRst_i,
  input  logic       signal_i,
  input  edge_mode_t mode_i,
  input  logic       clr_i,
  output logic       level_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       event_o,
  output logic       pending_o,
  output logic       pending_d_o
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   event_q, event_d;
  logic                   pending_q, pending_d;
  logic                   s;
  logic                   update;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], signal_i};
    cnt_d   = cnt_q;
    level_d = level_q;
    update  = 1'b0;
    // Any agreement with the current level restarts the stability count
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = s;
      cnt_d   = '0;
      update  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    rise_d    = update & s;
    fall_d    = update & ~s;
    event_d   = edge_select(mode_i, rise_d, fall_d);
    // A new event beats a simultaneous clear so nothing is lost
    pending_d = event_q | (pending_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge nRst_i) begin
    if (!nRst_i) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      event_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      event_q   <= event_d;
      pending_q <= pending_d;
    end
  end

  assign level_o     = level_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign event_o     = event_q;
  assign pending_o   = pending_q;
  assign pending_d_o = pending_d;

endmodule

// File: rtl/signal_conditioner.sv
// rtl/signal_conditioner.sv - multi-channel input conditioner between raw pins and protocol FSMs
module signal_conditioner
  import signal_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic                  clk_i,
  input  logic                  nRst_i,
  input  logic [CHANNELS-1:0]   signal_i,
  input  logic [2*CHANNELS-1:0] mode_i,
  input  logic [CHANNELS-1:0]   clr_i,
  output logic [CHANNELS-1:0]   level_o,
  output logic [CHANNELS-1:0]   rise_o,
  output logic [CHANNELS-1:0]   fall_o,
  output logic [CHANNELS-1:0]   event_o,
  output logic [CHANNELS-1:0]   pending_o,
  output logic                  any_pending_o
);

  logic [CHANNELS-1:0] pending_d;
  logic                any_pending_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    signal_conditioner_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_ch (
      .clk_i      (clk_i),
      .nRst_i     (nRst_i),
      .signal_i   (signal_i[i]),
      .mode_i     (edge_mode_t'(mode_i[2*i+:2])),
      .clr_i      (clr_i[i]),
      .level_o    (level_o[i]),
      .rise_o     (rise_o[i]),
      .fall_o     (fall_o[i]),
      .event_o    (event_o[i]),
      .pending_o  (pending_o[i]),
      .pending_d_o(pending_d[i])
    );
  end

  // Built from next-state pending so it changes on the same edge as pending
  always_ff @(posedge clk_i or negedge nRst_i) begin
    if (!nRst_i) begin
      any_pending_q <= 1'b0;
    end else begin
      any_pending_q <= |pending_d;
    end
  end

  assign any_pending_o = any_pending_q;

endmodule

// File: tb/tb_signal_conditioner.sv
// tb/tb_signal_conditioner.sv - directed self-checking bench for signal_conditioner
module tb_signal_conditioner;
  import signal_pkg::*;

  logic       clk;
  logic       nRst;
  logic [3:0] signal, clr, level, rise, fall, evt, pending;
  logic [7:0] mode;
  logic       any_pending;

  logic       sig1, clr1, level1, rise1, fall1, evt1, pending1, any1;
  logic [1:0] mode1;

  int checks = 0;
  int errors = 0;

  signal_conditioner u_dut (
    .clk_i        (clk),
    .nRst_i       (nRst),
    .signal_i     (signal),
    .mode_i       (mode),
    .clr_i        (clr),
    .level_o      (level),
    .rise_o       (rise),
    .fall_o       (fall),
    .event_o      (evt),
    .pending_o    (pending),
    .any_pending_o(any_pending)
  );

  signal_conditioner #(.CHANNELS(1), .SYNC_STAGES(3), .FILTER_CYCLES(1)) u_dut1 (
    .clk_i        (clk),
    .nRst_i       (nRst),
    .signal_i     (sig1),
    .mode_i       (mode1),
    .clr_i        (clr1),
    .level_o      (level1),
    .rise_o       (rise1),
    .fall_o       (fall1),
    .event_o      (evt1),
    .pending_o    (pending1),
    .any_pending_o(any1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nRst   = 1'b0;
    signal = 4'b0000;
    clr    = 4'b0000;
    mode   = {EDGE_BOTH, EDGE_BOTH, EDGE_BOTH, EDGE_BOTH};
    sig1   = 1'b0;
    clr1   = 1'b0;
    mode1  = EDGE_BOTH;

    // Reset state
    #2;
    check("rst_level", 32'(level), 32'h0);
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_fall", 32'(fall), 32'h0);
    check("rst_event", 32'(evt), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_any", 32'(any_pending), 32'h0);

    // 1: latency of 5 edges, single-cycle pulses, pending one edge later
    nRst      = 1'b1;
    signal[0] = 1'b1;
    repeat (4) step();
    check("t1_level_e4", 32'(level[0]), 32'h0);
    check("t1_rise_e4", 32'(rise[0]), 32'h0);
    step();
    check("t1_level_e5", 32'(level[0]), 32'h1);
    check("t1_rise_e5", 32'(rise[0]), 32'h1);
    check("t1_event_e5", 32'(evt[0]), 32'h1);
    check("t1_pend_e5", 32'(pending[0]), 32'h0);
    step();
    check("t1_rise_e6", 32'(rise[0]), 32'h0);
    check("t1_event_e6", 32'(evt[0]), 32'h0);
    check("t1_pend_e6", 32'(pending[0]), 32'h1);
    check("t1_any_e6", 32'(any_pending), 32'h1);
    check("t1_level_e6", 32'(level[0]), 32'h1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    check("t1_pend_clr", 32'(pending[0]), 32'h0);
    check("t1_any_clr", 32'(any_pending), 32'h0);
    signal[0] = 1'b0;
    repeat (4) step();
    check("t1_fall_e4", 32'(fall[0]), 32'h0);
    step();
    check("t1_fall_e5", 32'(fall[0]), 32'h1);
    check("t1_level_low", 32'(level[0]), 32'h0);
    step();
    check("t1_fall_e6", 32'(fall[0]), 32'h0);
    check("t1_pend_fall", 32'(pending[0]), 32'h1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    check("t1_pend_clr2", 32'(pending[0]), 32'h0);

    // 2: two-sample glitch rejected, three-sample pulse accepted
    signal[0] = 1'b1;
    repeat (2) step();
    signal[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("t2_glitch_level", 32'(level[0]), 32'h0);
      check("t2_glitch_event", 32'(evt[0] | rise[0]), 32'h0);
    end
    signal[0] = 1'b1;
    repeat (3) step();
    signal[0] = 1'b0;
    step();
    check("t2_level_pre", 32'(level[0]), 32'h0);
    step();
    check("t2_level_up", 32'(level[0]), 32'h1);
    check("t2_rise", 32'(rise[0]), 32'h1);
    step();
    check("t2_level_h2", 32'(level[0]), 32'h1);
    check("t2_edges_h2", 32'(rise[0] | fall[0]), 32'h0);
    step();
    check("t2_level_h3", 32'(level[0]), 32'h1);
    step();
    check("t2_level_dn", 32'(level[0]), 32'h0);
    check("t2_fall", 32'(fall[0]), 32'h1);
    repeat (2) step();
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;

    // 3: channel 1 reports only falling edges
    mode = {EDGE_BOTH, EDGE_BOTH, EDGE_FALL, EDGE_BOTH};
    signal[1] = 1'b1;
    repeat (5) step();
    check("t3_rise", 32'(rise[1]), 32'h1);
    check("t3_event_rise", 32'(evt[1]), 32'h0);
    repeat (5) step();
    check("t3_pend_after_rise", 32'(pending[1]), 32'h0);
    check("t3_level_hi", 32'(level[1]), 32'h1);
    signal[1] = 1'b0;
    repeat (5) step();
    check("t3_fall", 32'(fall[1]), 32'h1);
    check("t3_event_fall", 32'(evt[1]), 32'h1);
    check("t3_pend_at_fall", 32'(pending[1]), 32'h0);
    step();
    check("t3_pend_after_fall", 32'(pending[1]), 32'h1);
    clr[1] = 1'b1;
    step();
    clr[1] = 1'b0;
    check("t3_pend_clr", 32'(pending[1]), 32'h0);

    // 4: clear coinciding with an event loses to the set
    check("t4_any_start", 32'(any_pending), 32'h0);
    signal[2] = 1'b1;
    repeat (5) step();
    check("t4_event", 32'(evt[2]), 32'h1);
    clr[2] = 1'b1;
    step();
    check("t4_pend_race", 32'(pending[2]), 32'h1);
    check("t4_any_race", 32'(any_pending), 32'h1);
    step();
    clr[2] = 1'b0;
    check("t4_pend_clr", 32'(pending[2]), 32'h0);
    check("t4_any_clr", 32'(any_pending), 32'h0);

    // 5: asynchronous reset in the middle of a count
    signal[3] = 1'b1;
    repeat (3) step();
    check("t5_level_pre", 32'(level), 32'h4);
    #2;
    nRst = 1'b0;
    #1;
    check("t5_level_async", 32'(level), 32'h0);
    check("t5_rise_async", 32'(rise | fall | evt), 32'h0);
    check("t5_pend_async", 32'({any_pending, pending}), 32'h0);
    step();
    nRst = 1'b1;
    repeat (4) step();
    check("t5_rise_e4", 32'(rise), 32'h0);
    step();
    check("t5_rise_e5", 32'(rise), 32'hC);
    check("t5_level_e5", 32'(level), 32'hC);

    // 6: single channel, three sync stages, no filtering
    sig1 = 1'b1;
    repeat (3) step();
    check("t6_level_e3", 32'(level1), 32'h0);
    step();
    check("t6_level_e4", 32'(level1), 32'h1);
    check("t6_rise_e4", 32'(rise1), 32'h1);
    repeat (2) step();
    sig1 = 1'b0;
    step();
    sig1 = 1'b1;
    repeat (2) step();
    check("t6_level_pulse_pre", 32'(level1), 32'h1);
    step();
    check("t6_fall", 32'(fall1), 32'h1);
    check("t6_level_lo", 32'(level1), 32'h0);
    step();
    check("t6_rise_again", 32'(rise1), 32'h1);
    check("t6_level_back", 32'(level1), 32'h1);
    check("t6_pend", 32'(pending1), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
